vector_memory_responder: RTL and testbench

VECTOR_MEMORY_RESPONDER -- requirements
Module: vector_memory_responder

---
 rtl/vpu_pkg.sv | 19 +
 rtl/vector_memory_responder_if.sv | 31 +++
 rtl/vmem_sram_1rw.sv | 35 +++
 rtl/vector_memory_responder.sv | 130 +++++++++++++
 tb/tb_vector_memory_responder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared widths, limits and FSM encoding for the vector memory responder
package vpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int VL_W   = 7;
    localparam int MAX_VL = 64;

    localparam logic LS_LOAD  = 1'b1;
    localparam logic LS_STORE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STORE  = 2'd2,
        ST_FINISH = 2'd3
    } vmr_state_t;

endpackage

// File: rtl/vector_memory_responder_if.sv
// rtl/vector_memory_responder_if.sv - request, store-data and load-data bundle of the vector memory responder
interface vector_memory_responder_if #(
    parameter int DATA_W = vpu_pkg::DATA_W,
    parameter int VL_W   = vpu_pkg::VL_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [31:0]       req_addr;
    logic [VL_W-1:0]   req_vl;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_load, req_addr, req_vl, wdata, wdata_valid,
        input  req_ready, wdata_ready, rdata, rdata_valid, busy, done, err
    );

    modport slave (
        input  req_valid, req_load, req_addr, req_vl, wdata, wdata_valid,
        output req_ready, wdata_ready, rdata, rdata_valid, busy, done, err
    );

endinterface

// File: rtl/vmem_sram_1rw.sv
// rtl/vmem_sram_1rw.sv - single-port synchronous RAM with write enable and registered read
module vmem_sram_1rw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only updates on reads, so it holds across writes and idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/vector_memory_responder.sv
// rtl/vector_memory_responder.sv - burst load/store responder: request FSM, element counter and range check over one RAM
module vector_memory_responder #(
    parameter int DATA_W = vpu_pkg::DATA_W,
    parameter int ADDR_W = vpu_pkg::ADDR_W,
    parameter int VL_W   = vpu_pkg::VL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    vector_memory_responder_if.slave   bus
);

    import vpu_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    vmr_state_t        state_q;
    vmr_state_t        state_d;
    logic [VL_W-1:0]   cnt_q;
    logic [VL_W-1:0]   vl_q;
    logic [ADDR_W-1:0] base_q;
    logic              err_q;
    logic              rdata_valid_q;

    logic              accept;
    logic              req_bad;
    logic [33:0]       req_end;
    logic              rd_issue;
    logic              wr_fire;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // One past the last word touched; computed wide so no address can wrap.
    assign req_end = {2'b00, bus.req_addr} + {{(34 - VL_W){1'b0}}, bus.req_vl};
    assign req_bad = (bus.req_vl == '0)
                  || (int'(bus.req_vl) > MAX_VL)
                  || (req_end > 34'(DEPTH));

    always_comb begin
        accept          = 1'b0;
        rd_issue        = 1'b0;
        wr_fire         = 1'b0;
        bus.req_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        bus.busy        = 1'b1;
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        state_d         = state_q;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                accept        = bus.req_valid;
                if (bus.req_valid) begin
                    if (req_bad) begin
                        state_d = ST_FINISH;
                    end else if (bus.req_load == LS_LOAD) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_STORE;
                    end
                end
            end
            ST_LOAD: begin
                // One extra cycle after the last issue lets its data drain before done.
                rd_issue = (cnt_q != vl_q);
                if (cnt_q == vl_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_STORE: begin
                bus.wdata_ready = 1'b1;
                wr_fire         = bus.wdata_valid;
                if (bus.wdata_valid && (cnt_q == vl_q - VL_W'(1))) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                bus.done = 1'b1;
                bus.err  = err_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            vl_q          <= '0;
            base_q        <= '0;
            err_q         <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdata_valid_q <= rd_issue;
            if (accept) begin
                base_q <= bus.req_addr[ADDR_W-1:0];
                vl_q   <= bus.req_vl;
                err_q  <= req_bad;
                cnt_q  <= '0;
            end else if (rd_issue || wr_fire) begin
                cnt_q <= cnt_q + VL_W'(1);
            end
        end
    end

    assign ram_en   = rd_issue || wr_fire;
    assign ram_addr = base_q + ADDR_W'(cnt_q);

    vmem_sram_1rw #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (wr_fire),
        .addr  (ram_addr),
        .wdata (bus.wdata),
        .rdata (ram_rdata)
    );

    assign bus.rdata       = ram_rdata;
    assign bus.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_vector_memory_responder.sv
// tb/tb_vector_memory_responder.sv - self-checking bench for vector_memory_responder with a load-data scoreboard
module tb_vector_memory_responder;

    import vpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vector_memory_responder_if #(.DATA_W(32), .VL_W(7)) bus();

    vector_memory_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [256];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bad_req(input logic [31:0] a, input int vl);
        return (vl == 0) || (vl > 64) || (longint'(a) + longint'(vl) > 256);
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.rdata_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("rdata_unexpected", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("rdata", bus.rdata, mon_exp);
            end
        end
    end

    task automatic drive_req(input bit load, input logic [31:0] addr, input int vl);
        @(negedge clk);
        check_eq("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_load  = load ? LS_LOAD : LS_STORE;
        bus.req_addr  = addr;
        bus.req_vl    = 7'(vl);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input int vl, input logic [31:0] dbase, input bit toggle);
        int idx;
        int sent;
        int exp_done;
        int done_idx;
        bit bad;
        bad      = bad_req(addr, vl);
        exp_done = bad ? 1 : -1;
        drive_req(1'b0, addr, vl);
        idx      = 0;
        sent     = 0;
        done_idx = -1;
        while (done_idx < 0 && idx < 200) begin
            @(negedge clk);
            idx++;
            bus.wdata_valid = 1'b0;
            if (bus.done) begin
                done_idx = idx;
                check_eq("store_err", bus.err, bad);
            end else if (sent < vl && (!toggle || (idx % 2 == 1))) begin
                if (!bad) begin
                    check_eq("store_wdata_ready", bus.wdata_ready, 1);
                    model[addr + sent] = dbase + sent;
                end
                bus.wdata_valid = 1'b1;
                bus.wdata       = dbase + sent;
                sent++;
                if (sent == vl && !bad) exp_done = idx + 1;
            end
        end
        if (done_idx < 0) check_eq("store_timeout", 0, 1);
        else check_eq("store_done_latency", done_idx, exp_done);
        // Junk data outside STORE must never reach memory.
        bus.wdata_valid = 1'b1;
        bus.wdata       = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        bus.wdata_valid = 1'b0;
    endtask

    task automatic wait_load(input int vl, input bit bad, input int tag_base);
        int idx;
        int rv;
        int first_rv;
        int done_idx;
        logic [31:0] last;
        idx      = 0;
        rv       = 0;
        first_rv = -1;
        done_idx = -1;
        last     = '0;
        while (done_idx < 0 && idx < 200) begin
            @(negedge clk);
            idx++;
            if (bus.rdata_valid) begin
                rv++;
                last = bus.rdata;
                if (first_rv < 0) first_rv = idx;
            end
            if (bus.done) begin
                done_idx = idx;
                check_eq($sformatf("load%0d_err", tag_base), bus.err, bad);
            end
        end
        if (done_idx < 0) check_eq("load_timeout", 0, 1);
        else check_eq($sformatf("load%0d_done_latency", tag_base), done_idx, bad ? 1 : vl + 2);
        check_eq($sformatf("load%0d_rvalid_count", tag_base), rv, bad ? 0 : vl);
        if (!bad) begin
            check_eq($sformatf("load%0d_first_rvalid", tag_base), first_rv, 2);
            @(negedge clk);
            check_eq("rdata_hold", bus.rdata, last);
        end
        check_eq("rdata_missing", exp_q.size(), 0);
    endtask

    task automatic do_load(input logic [31:0] addr, input int vl, input int tag);
        bit bad;
        bad = bad_req(addr, vl);
        drive_req(1'b1, addr, vl);
        if (!bad) for (int i = 0; i < vl; i++) exp_q.push_back(model[addr + i]);
        wait_load(vl, bad, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int done_idx;
        int early_ready;
        bus.req_valid   = 1'b0;
        bus.req_load    = 1'b0;
        bus.req_addr    = '0;
        bus.req_vl      = '0;
        bus.wdata       = '0;
        bus.wdata_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_rdata_valid", bus.rdata_valid, 0);
        check_eq("rst_wdata_ready", bus.wdata_ready, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        rst = 1'b0;

        do_store(32'h00, 64, 32'h1000, 1'b0);
        do_store(32'h10, 4, 32'hA0, 1'b0);
        do_load(32'h10, 4, 1);

        do_store(32'h40, 8, 32'h2000, 1'b0);
        do_store(32'h40, 3, 32'hC0, 1'b1);
        do_load(32'h40, 4, 2);

        do_store(32'hFE, 2, 32'h3000, 1'b0);
        do_load(32'hFE, 4, 3);
        do_load(32'h20, 0, 4);
        do_load(32'h20, 65, 5);
        do_store(32'hFE, 4, 32'h7700, 1'b0);
        do_load(32'hFE, 2, 6);

        // Second request held valid throughout a 64-element load.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_load  = LS_LOAD;
        bus.req_addr  = 32'h0;
        bus.req_vl    = 7'd64;
        @(posedge clk);
        for (int i = 0; i < 64; i++) exp_q.push_back(model[i]);
        #1;
        bus.req_addr = 32'h40;
        bus.req_vl   = 7'd4;
        idx          = 0;
        done_idx     = -1;
        early_ready  = 0;
        while (done_idx < 0 && idx < 200) begin
            @(negedge clk);
            idx++;
            if (bus.done) done_idx = idx;
            else if (bus.req_ready) early_ready++;
        end
        check_eq("b2b_done_latency", done_idx, 66);
        check_eq("b2b_ready_while_busy", early_ready, 0);
        @(negedge clk);
        check_eq("b2b_ready_first_idle", bus.req_ready, 1);
        @(posedge clk);
        for (int i = 0; i < 4; i++) exp_q.push_back(model[32'h40 + i]);
        #1 bus.req_valid = 1'b0;
        wait_load(4, 1'b0, 7);

        // Asynchronous reset after two of eight store elements.
        do_store(32'h80, 8, 32'h4000, 1'b0);
        drive_req(1'b0, 32'h80, 8);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.wdata_valid = 1'b1;
            bus.wdata       = 32'h5000 + k;
            model[32'h80 + k] = 32'h5000 + k;
        end
        @(negedge clk);
        bus.wdata = 32'hBAD0;
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_req_ready", bus.req_ready, 1);
        check_eq("midrst_wdata_ready", bus.wdata_ready, 0);
        check_eq("midrst_done", bus.done, 0);
        check_eq("midrst_err", bus.err, 0);
        check_eq("midrst_rdata_valid", bus.rdata_valid, 0);
        check_eq("midrst_rdata", bus.rdata, 0);
        @(negedge clk);
        bus.wdata_valid = 1'b0;
        rst = 1'b0;
        do_load(32'h80, 8, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
